// File: rtl/data_write_buffer.sv
// Posted-write FIFO between the CPU data port and data memory.
// Stores are accepted in one cycle and drained in the background; loads that hit a pending store stall until it drains.
module data_write_buffer #(
  parameter int unsigned DEPTH = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] cpu_address,
  input  logic        cpu_write,
  input  logic        cpu_read,
  input  logic [31:0] cpu_writedata,
  input  logic [3:0]  cpu_byteenable,
  output logic [31:0] cpu_readdata,
  output logic        cpu_waitrequest,
  output logic [31:0] mem_address,
  output logic        mem_write,
  output logic        mem_read,
  output logic [31:0] mem_writedata,
  output logic [3:0]  mem_byteenable,
  input  logic [31:0] mem_readdata,
  input  logic        mem_waitrequest,
  output logic        buffer_empty,
  output logic        protocol_error
);

  localparam int unsigned PW = $clog2(DEPTH);

  logic [29:0]   addr_q [DEPTH];
  logic [31:0]   data_q [DEPTH];
  logic [3:0]    be_q   [DEPTH];

  logic [PW-1:0] head_q, head_d;
  logic [PW-1:0] tail_q, tail_d;
  logic [PW:0]   count_q, count_d;
  logic          perr_q, perr_d;

  logic          rd, wr_req, hit, load_miss, full, drain, push, pop;
  logic [PW-1:0] offs;

  // Byte offset bits of the CPU address are meaningless for word accesses.
  logic unused_addr_lsb;
  assign unused_addr_lsb = ^cpu_address[1:0];

  // An entry is live when its distance from head is below count.
  always_comb begin
    hit  = 1'b0;
    offs = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      offs = PW'(i) - head_q;
      if (({1'b0, offs} < count_q) && (addr_q[i] == cpu_address[31:2]))
        hit = 1'b1;
    end
  end

  // A simultaneous read and write is served as a load only.
  always_comb begin
    rd        = ~reset & cpu_read;
    wr_req    = ~reset & cpu_write & ~cpu_read;
    load_miss = rd & ~hit;
    full      = (count_q == (PW+1)'(DEPTH));
    drain     = ~reset & ~load_miss & (count_q != '0);
    push      = wr_req & ~full;
    pop       = drain & ~mem_waitrequest;
  end

  always_comb begin
    mem_read        = load_miss;
    mem_write       = drain;
    mem_address     = '0;
    mem_writedata   = '0;
    mem_byteenable  = '0;
    cpu_readdata    = '0;
    cpu_waitrequest = 1'b0;
    if (load_miss) begin
      mem_address  = {cpu_address[31:2], 2'b00};
      cpu_readdata = mem_readdata;
    end else if (drain) begin
      mem_address    = {addr_q[head_q], 2'b00};
      mem_writedata  = data_q[head_q];
      mem_byteenable = be_q[head_q];
    end
    if (rd)
      cpu_waitrequest = hit | mem_waitrequest;
    else if (wr_req)
      cpu_waitrequest = full;
  end

  assign buffer_empty   = (count_q == '0);
  assign protocol_error = perr_q;

  always_comb begin
    head_d  = head_q + PW'(pop);
    tail_d  = tail_q + PW'(push);
    count_d = count_q + (PW+1)'(push) - (PW+1)'(pop);
    perr_d  = perr_q | (cpu_read & cpu_write);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      perr_q  <= 1'b0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      perr_q  <= perr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      addr_q[tail_q] <= cpu_address[31:2];
      data_q[tail_q] <= cpu_writedata;
      be_q[tail_q]   <= cpu_byteenable;
    end
  end

endmodule

// File: tb/tb_data_write_buffer.sv
// Scoreboard bench for data_write_buffer: expected memory writes and load data are queued
// by the stimulus and consumed by a monitor whenever the DUT completes a transfer.
module tb_data_write_buffer;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] cpu_address;
  logic        cpu_write;
  logic        cpu_read;
  logic [31:0] cpu_writedata;
  logic [3:0]  cpu_byteenable;
  logic [31:0] cpu_readdata;
  logic        cpu_waitrequest;
  logic [31:0] mem_address;
  logic        mem_write;
  logic        mem_read;
  logic [31:0] mem_writedata;
  logic [3:0]  mem_byteenable;
  logic [31:0] mem_readdata;
  logic        mem_waitrequest;
  logic        buffer_empty;
  logic        protocol_error;

  data_write_buffer #(.DEPTH(4)) dut (
    .clk             (clk),
    .reset           (reset),
    .cpu_address     (cpu_address),
    .cpu_write       (cpu_write),
    .cpu_read        (cpu_read),
    .cpu_writedata   (cpu_writedata),
    .cpu_byteenable  (cpu_byteenable),
    .cpu_readdata    (cpu_readdata),
    .cpu_waitrequest (cpu_waitrequest),
    .mem_address     (mem_address),
    .mem_write       (mem_write),
    .mem_read        (mem_read),
    .mem_writedata   (mem_writedata),
    .mem_byteenable  (mem_byteenable),
    .mem_readdata    (mem_readdata),
    .mem_waitrequest (mem_waitrequest),
    .buffer_empty    (buffer_empty),
    .protocol_error  (protocol_error)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] d;
    logic [3:0]  be;
  } wr_t;

  int          checks = 0;
  int          errors = 0;
  wr_t         wq[$];
  logic [31:0] rq[$];
  logic [31:0] mem [64];

  assign mem_readdata = mem[mem_address[7:2]];

  always @(posedge clk) begin
    if (mem_write && !mem_waitrequest)
      for (int b = 0; b < 4; b++)
        if (mem_byteenable[b]) mem[mem_address[7:2]][8*b +: 8] <= mem_writedata[8*b +: 8];
  end

  task automatic chk(input string name, input logic [67:0] act, input logic [67:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic store(input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
    cpu_write      = 1'b1;
    cpu_read       = 1'b0;
    cpu_address    = a;
    cpu_writedata  = d;
    cpu_byteenable = be;
    wq.push_back({a, d, be});
  endtask

  task automatic wait_empty(input string name);
    int n;
    for (n = 0; n < 20; n++) begin
      @(negedge clk);
      if (buffer_empty) break;
    end
    chk(name, 68'(n < 20), 68'(1));
  endtask

  // Monitor: consumes expected transfers whenever memory completes one.
  initial begin
    wr_t         e;
    logic [31:0] r;
    forever begin
      @(negedge clk);
      if (mem_write || mem_read) chk("rw_exclusive", 68'(mem_write & mem_read), 68'(0));
      if (mem_write && !mem_waitrequest) begin
        if (wq.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_write: got addr %h data %h expected no write", mem_address, mem_writedata);
        end else begin
          e = wq.pop_front();
          chk("mem_write", {mem_address, mem_writedata, mem_byteenable}, e);
        end
      end
      if (cpu_read && mem_read && !cpu_waitrequest) begin
        if (rq.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_load: got addr %h expected no load", mem_address);
        end else begin
          r = rq.pop_front();
          chk("load_data", 68'(cpu_readdata), 68'(r));
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    int n;
    for (int i = 0; i < 64; i++) mem[i] = '0;
    mem[32] = 32'hCAFEF00D;

    // Reset with conflicting requests present: outputs must stay quiet.
    reset = 1'b1; mem_waitrequest = 1'b0;
    cpu_read = 1'b1; cpu_write = 1'b1; cpu_address = 32'h80;
    cpu_writedata = 32'h1; cpu_byteenable = 4'hF;
    #2;
    chk("rst_readdata", 68'(cpu_readdata), 68'(0));
    chk("rst_mem_read", 68'(mem_read), 68'(0));
    chk("rst_mem_write", 68'(mem_write), 68'(0));
    chk("rst_waitreq", 68'(cpu_waitrequest), 68'(0));
    chk("rst_empty", 68'(buffer_empty), 68'(1));
    #10;
    cpu_read = 1'b0; cpu_write = 1'b0; cpu_address = '0;
    chk("rst_perr", 68'(protocol_error), 68'(0));
    #10 reset = 1'b0;
    cyc();

    // Single store drains the following cycle.
    store(32'h10, 32'hDEADBEEF, 4'hF);
    @(negedge clk);
    chk("t1_waitreq", 68'(cpu_waitrequest), 68'(0));
    chk("t1_empty_before", 68'(buffer_empty), 68'(1));
    cyc();
    cpu_write = 1'b0;
    @(negedge clk);
    chk("t1_mem_write", {35'(mem_write), mem_address}, {35'(1), 32'h10});
    cyc();
    @(negedge clk);
    chk("t1_empty_after", 68'(buffer_empty), 68'(1));

    // Fill the buffer with memory stalled; fifth store waits for a freed slot.
    cyc();
    mem_waitrequest = 1'b1;
    store(32'h00, 32'h10000000, 4'h1); @(negedge clk); chk("t2_acc0", 68'(cpu_waitrequest), 68'(0)); cyc();
    store(32'h04, 32'h10000004, 4'h3); @(negedge clk); chk("t2_acc1", 68'(cpu_waitrequest), 68'(0)); cyc();
    store(32'h08, 32'h10000008, 4'hF); @(negedge clk); chk("t2_acc2", 68'(cpu_waitrequest), 68'(0)); cyc();
    store(32'h0C, 32'h1000000C, 4'h0); @(negedge clk); chk("t2_acc3", 68'(cpu_waitrequest), 68'(0)); cyc();
    store(32'h20, 32'h10000020, 4'hC);
    @(negedge clk);
    chk("t2_full_stall", 68'(cpu_waitrequest), 68'(1));
    cyc();
    mem_waitrequest = 1'b0;
    @(negedge clk);
    chk("t2_full_same_edge", 68'(cpu_waitrequest), 68'(1));
    cyc();
    @(negedge clk);
    chk("t2_fifth_accept", 68'(cpu_waitrequest), 68'(0));
    cyc();
    cpu_write = 1'b0;
    wait_empty("t2_drain");

    // Load hitting a pending store stalls until it has drained.
    cyc();
    mem_waitrequest = 1'b1;
    store(32'h40, 32'hAAAA0040, 4'hF); cyc();
    store(32'h44, 32'h55550044, 4'hF); cyc();
    cpu_write = 1'b0; cpu_read = 1'b1; cpu_address = 32'h44;
    rq.push_back(32'h55550044);
    @(negedge clk);
    chk("t3_hit_wait", 68'(cpu_waitrequest), 68'(1));
    chk("t3_hit_noread", 68'(mem_read), 68'(0));
    cyc();
    mem_waitrequest = 1'b0;
    for (n = 0; n < 10; n++) begin
      @(negedge clk);
      if (!cpu_waitrequest) break;
    end
    chk("t3_stall_cycles", 68'(n), 68'(2));
    chk("t3_read_issued", {35'(mem_read), mem_address}, {35'(1), 32'h44});
    cyc();
    cpu_read = 1'b0;

    // Load miss takes priority over a pending drain.
    mem_waitrequest = 1'b1;
    store(32'h40, 32'h12345678, 4'hF); cyc();
    cpu_write = 1'b0; cpu_read = 1'b1; cpu_address = 32'h80;
    mem_waitrequest = 1'b0;
    rq.push_back(32'hCAFEF00D);
    @(negedge clk);
    chk("t4_miss_read", {35'(mem_read), mem_address}, {35'(1), 32'h80});
    chk("t4_miss_nowrite", 68'(mem_write), 68'(0));
    chk("t4_miss_wait", 68'(cpu_waitrequest), 68'(0));
    cyc();
    cpu_read = 1'b0;
    @(negedge clk);
    chk("t4_drain_resume", {35'(mem_write), mem_address}, {35'(1), 32'h40});
    wait_empty("t4_drain");

    // Asynchronous reset mid-way discards pending stores.
    cyc();
    mem_waitrequest = 1'b1;
    store(32'h60, 32'h60606060, 4'hF); cyc();
    store(32'h64, 32'h64646464, 4'hF); cyc();
    store(32'h68, 32'h68686868, 4'hF); cyc();
    cpu_write = 1'b0;
    #2 reset = 1'b1;
    wq.delete();
    #1;
    chk("t5_rst_empty", 68'(buffer_empty), 68'(1));
    chk("t5_rst_nowrite", 68'(mem_write), 68'(0));
    @(posedge clk); @(posedge clk);
    #3 reset = 1'b0; mem_waitrequest = 1'b0;
    repeat (5) begin
      @(negedge clk);
      chk("t5_no_write", {67'(buffer_empty), mem_write}, {67'(1), 1'b0});
    end
    cyc();

    // Read and write together: load only, sticky protocol error.
    cpu_read = 1'b1; cpu_write = 1'b1; cpu_address = 32'h08;
    cpu_writedata = 32'hFFFFFFFF; cpu_byteenable = 4'hF;
    rq.push_back(32'h10000008);
    @(negedge clk);
    chk("t6_read", {35'(mem_read), mem_address}, {35'(1), 32'h08});
    chk("t6_nowrite", 68'(mem_write), 68'(0));
    chk("t6_wait", 68'(cpu_waitrequest), 68'(0));
    cyc();
    cpu_read = 1'b0; cpu_write = 1'b0;
    @(negedge clk);
    chk("t6_empty", 68'(buffer_empty), 68'(1));
    chk("t6_perr_set", 68'(protocol_error), 68'(1));
    repeat (3) cyc();
    @(negedge clk);
    chk("t6_perr_held", {67'(protocol_error), mem_write}, {67'(1), 1'b0});

    repeat (2) cyc();
    chk("wq_drained", 68'(wq.size()), 68'(0));
    chk("rq_drained", 68'(rq.size()), 68'(0));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/data_write_buffer.md
Name: data_write_buffer

Overview:
- Posted-write FIFO between the Harvard CPU data port and the data memory.
- CPU stores are accepted in one cycle and drained to memory in the background. Loads bypass pending stores unless they hit a buffered word; in that case the buffer drains until no buffered entry matches, then the load is issued.
- buffer_empty lets CPU halt logic hold active=1 until every store has reached memory.

Parameters:
DEPTH, 4, number of buffered store entries (power of two, >=2)

Ports:
clk  input  1  system clock, all state updates on rising edge
reset  input  1  asynchronous active-high reset
cpu_address  input  32  CPU data byte address; bits [1:0] ignored
cpu_write  input  1  CPU store request
cpu_read  input  1  CPU load request
cpu_writedata  input  32  store data
cpu_byteenable  input  4  store byte lanes
cpu_readdata  output  32  load data
cpu_waitrequest  output  1  stall CPU; request must be held until low
mem_address  output  32  memory word address (bits [1:0]=0)
mem_write  output  1  memory write strobe
mem_read  output  1  memory read strobe
mem_writedata  output  32  memory write data
mem_byteenable  output  4  memory write byte lanes
mem_readdata  input  32  memory read data, valid in the same cycle as mem_read
mem_waitrequest  input  1  memory stall; an op completes on an edge where it is low
buffer_empty  output  1  no pending stores
protocol_error  output  1  sticky: cpu_read and cpu_write both seen high

Behaviour:
- Reset (async, any cycle, including mid-drain): count=0, head=tail=0, all entries discarded, protocol_error=0. Outputs during reset: mem_write=0, mem_read=0, cpu_waitrequest=0, buffer_empty=1, cpu_readdata=0.
- Entry: {word address [31:2], data, byteenable}. count has width clog2(DEPTH)+1. Pointers wrap modulo DEPTH.
- Store, count<DEPTH: cpu_waitrequest=0; enqueue at tail on this edge.
- Store, count==DEPTH: cpu_waitrequest=1. A slot freed by a pop on the same edge is visible next cycle only, so a store never enqueues on the edge it first sees a full buffer.
- Store with byteenable=0: accepted and enqueued. On drain, mem_write asserts with byteenable 0.
- Load hit (any valid entry matches the word address): cpu_waitrequest=1, mem_read=0, draining continues. The load is re-evaluated each cycle. Merging and forwarding are not performed.
- Load miss: mem_read=1 and mem_address=cpu word address, combinationally. cpu_readdata=mem_readdata. cpu_waitrequest=mem_waitrequest. The load has priority over draining, so mem_write=0 that cycle.
- Drain: when count>0 and no load miss is being issued, mem_write=1 with the head entry on the mem_* outputs. Pop on an edge where mem_waitrequest=0.
- Maximum throughput: one enqueue and one pop on the same edge. count is unchanged and both pointers advance.
- mem_read and mem_write are never high in the same cycle.
- Both cpu_read and cpu_write high: treated as a load, the store is ignored, protocol_error sets and stays set until reset.
- buffer_empty = (count==0), combinational from state.
- Load-miss latency: 0 extra cycles over bare memory. Store latency to the CPU: 0 cycles unless full.

Test Plan:
- Reset, then store 0xDEADBEEF to 0x10 with byteenable 0xF, mem_waitrequest=0 -> cpu_waitrequest=0 on the store cycle; next cycle mem_write=1, mem_address=0x10, mem_writedata=0xDEADBEEF; buffer_empty=1 after that edge.
- mem_waitrequest held at 1, five stores to 0x0,0x4,0x8,0xC,0x20 -> first four accepted; fifth sees cpu_waitrequest=1; release memory -> the fifth store enqueues one cycle after the first pop; memory receives all five in order.
- Stores pending to 0x40 and 0x44, then load 0x44 -> cpu_waitrequest=1 until both entries are popped; then mem_read=1 at 0x44 and cpu_readdata equals the stored value.
- Stores pending to 0x40, then load 0x80 (miss) -> mem_read=1 the same cycle, mem_write=0; drain of 0x40 resumes the following cycle.
- Three stores pending, assert reset asynchronously between clock edges -> buffer_empty=1 and mem_write=0 immediately; no further memory writes after reset deasserts.
- cpu_read and cpu_write both high at 0x8 -> load performed, no store enqueued (buffer_empty stays 1), protocol_error=1 and held.
